// File: rtl/cic_interp_if.sv
// Sample-stream bundle between the upstream source, the CIC interpolator and the DAC side.
interface cic_interp_if #(
  parameter int NIN  = 12,
  parameter int NOUT = 17
);
  logic signed [NIN-1:0]  din;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [NOUT-1:0] dout;
  logic                   dout_valid;
  logic                   underflow;

  modport master (output din, output in_valid, input in_ready,
                  input dout, input dout_valid, input underflow);
  modport slave  (input din, input in_valid, output in_ready,
                  output dout, output dout_valid, output underflow);
endinterface

// File: rtl/cic_interp.sv
// CIC interpolator: N low-rate combs, zero-stuffing by R, N high-rate integrators,
// truncated to the top NOUT bits. All internal math wraps modulo 2^NMAX.
module cic_interp #(
  parameter int NIN  = 12,
  parameter int R    = 8,
  parameter int N    = 3,
  parameter int M    = 1,
  parameter int NMAX = 21,
  parameter int NOUT = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  cic_interp_if.slave bus
);
  localparam int PW = (R > 1) ? $clog2(R) : 1;
  localparam logic [PW-1:0] PH_ZERO = PW'(1'b0);
  localparam logic [PW-1:0] PH_ONE  = PW'(1'b1);

  logic [PW-1:0]          ph_r;
  logic                   slot_s;
  logic                   accept_s;
  logic signed [NMAX-1:0] stage_s [0:N-1];
  logic signed [NMAX-1:0] comb_s;
  logic signed [NMAX-1:0] dly_r   [0:N-1][0:M-1];
  logic signed [NMAX-1:0] comb_r;
  logic                   pend_r;
  logic signed [NMAX-1:0] u_s;
  logic signed [NMAX-1:0] integ_r [0:N-1];
  logic signed [NOUT-1:0] dout_r;
  logic                   dout_valid_r;
  logic                   underflow_r;

  // accept slot: first enabled cycle of every R-cycle period
  always_comb begin
    slot_s   = en & (ph_r == PH_ZERO) & ~rst;
    accept_s = slot_s & bus.in_valid;
  end

  // comb cascade evaluated combinationally within the accept cycle
  always_comb begin
    logic signed [NMAX-1:0] x_v;
    x_v = {{(NMAX-NIN){bus.din[NIN-1]}}, bus.din};
    for (int k = 0; k < N; k++) begin
      stage_s[k] = x_v;
      x_v        = x_v - dly_r[k][M-1];
    end
    comb_s = x_v;
  end

  // zero-stuffing: the comb result enters the integrators only once per accepted period
  always_comb begin
    if (pend_r && (ph_r == PH_ONE)) begin
      u_s = comb_r;
    end else begin
      u_s = {NMAX{1'b0}};
    end
  end

  // phase counter; R is a power of two so natural overflow is the wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_r <= PH_ZERO;
    end else if (en) begin
      ph_r <= ph_r + PH_ONE;
    end
  end

  // comb delay lines and comb result advance on accepts only; a missed slot leaves them intact
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < M; j++) begin
          dly_r[k][j] <= {NMAX{1'b0}};
        end
      end
      comb_r <= {NMAX{1'b0}};
      pend_r <= 1'b0;
    end else if (slot_s) begin
      pend_r <= bus.in_valid;
      if (accept_s) begin
        for (int k = 0; k < N; k++) begin
          dly_r[k][0] <= stage_s[k];
          for (int j = 1; j < M; j++) begin
            dly_r[k][j] <= dly_r[k][j-1];
          end
        end
        comb_r <= comb_s;
      end
    end
  end

  // integrator chain at the enabled clock rate
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        integ_r[k] <= {NMAX{1'b0}};
      end
    end else if (en) begin
      integ_r[0] <= integ_r[0] + u_s;
      for (int k = 1; k < N; k++) begin
        integ_r[k] <= integ_r[k] + integ_r[k-1];
      end
    end
  end

  // registered outputs; dout holds while en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r       <= {NOUT{1'b0}};
      dout_valid_r <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      dout_valid_r <= en;
      underflow_r  <= slot_s & ~bus.in_valid;
      if (en) begin
        dout_r <= integ_r[N-1][NMAX-1 -: NOUT];
      end
    end
  end

  assign bus.in_ready   = slot_s;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.underflow  = underflow_r;
endmodule
